// File: rtl/reset_pkg.sv
// Shared types and constants for the reset source controller.
package reset_pkg;

  // Controller state: HOLD keeps the system in reset, RUN lets it run.
  typedef enum logic {HOLD = 1'b0, RUN = 1'b1} rst_state_t;

  // Cause bits, LSB first: power-on, button, software, watchdog.
  typedef struct packed {
    logic wdt;
    logic sw;
    logic btn;
    logic por;
  } rst_cause_t;

  localparam logic [3:0] CAUSE_POR = 4'b0001;
  localparam logic [3:0] CAUSE_BTN = 4'b0010;
  localparam logic [3:0] CAUSE_SW  = 4'b0100;
  localparam logic [3:0] CAUSE_WDT = 4'b1000;

  // Counter width for a counter that must reach n-1; never narrower than 1 bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer followed by a saturating
// debounce counter. btn_pressed rises once the synchronized button has read
// low for DEBOUNCE_CYCLES-1 consecutive cycles and falls on the first high read.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic btn_pressed
);
  import reset_pkg::*;

  localparam int            CW      = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  // Counter value one edge before saturation; pressed rises on the same edge
  // the counter lands on CNT_MAX.
  localparam logic [CW-1:0] CNT_ARM = CW'(DEBOUNCE_CYCLES - 2);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Two-flop synchronizer; idles released (high) so reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  // Count consecutive low reads; saturate at CNT_MAX so a held button never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      btn_pressed <= 1'b0;
    end else if (sync2) begin
      cnt         <= '0;
      btn_pressed <= 1'b0;
    end else begin
      if (cnt != CNT_MAX) cnt <= cnt + CW'(1);
      if (cnt >= CNT_ARM) btn_pressed <= 1'b1;
    end
  end

endmodule

// File: rtl/reset_ctrl.sv
// Reset source controller: merges power-on, button, software and watchdog
// reset sources into one registered, minimum-width active-low reset request,
// and keeps a sticky record of what caused the last reset.
module reset_ctrl #(
  parameter int HOLD_CYCLES     = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int WDT_CYCLES      = 16777216
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          btn_n,
  input  logic                          sw_rst_req,
  input  logic                          wdt_en,
  input  logic                          wdt_kick,
  output logic                          sys_rst_n,
  output logic [3:0]                    rst_cause,
  output logic [$clog2(WDT_CYCLES)-1:0] wdt_count
);
  import reset_pkg::*;

  localparam int            HW        = cnt_w(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam int            WW        = $clog2(WDT_CYCLES);
  localparam logic [WW-1:0] WDT_LAST  = WW'(WDT_CYCLES - 1);

  rst_state_t    state;
  logic [HW-1:0] hold_cnt;
  logic          btn_pressed;
  logic          wdt_fire;
  logic          any_req;
  rst_cause_t    req_cause;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk         (clk),
    .rst         (rst),
    .btn_n       (btn_n),
    .btn_pressed (btn_pressed)
  );

  // Request decode: a kick in the terminal cycle beats the fire.
  always_comb begin
    wdt_fire      = (state == RUN) && wdt_en && !wdt_kick && (wdt_count == WDT_LAST);
    any_req       = wdt_fire || sw_rst_req || btn_pressed;
    req_cause     = '0;
    req_cause.wdt = wdt_fire;
    req_cause.sw  = sw_rst_req;
    req_cause.btn = btn_pressed;
  end

  // Hold/run FSM with registered reset output and sticky cause capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HOLD;
      hold_cnt  <= '0;
      sys_rst_n <= 1'b0;
      rst_cause <= CAUSE_POR;
    end else begin
      case (state)
        HOLD: begin
          // A held button keeps restarting the hold window, so release is
          // always followed by a full HOLD_CYCLES of reset.
          if (btn_pressed) begin
            hold_cnt <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state     <= RUN;
            sys_rst_n <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        RUN: begin
          if (any_req) begin
            state     <= HOLD;
            sys_rst_n <= 1'b0;
            hold_cnt  <= '0;
            rst_cause <= req_cause;
          end
        end
        default: begin
          state     <= HOLD;
          sys_rst_n <= 1'b0;
          hold_cnt  <= '0;
        end
      endcase
    end
  end

  // Watchdog: counts in RUN while enabled; any reset entry clears it so the
  // count never wraps past WDT_LAST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdt_count <= '0;
    end else if (state == HOLD || !wdt_en || wdt_kick || any_req) begin
      wdt_count <= '0;
    end else begin
      wdt_count <= wdt_count + WW'(1);
    end
  end

endmodule

// File: tb/tb_reset_ctrl.sv
// Self-checking bench for reset_ctrl: directed scenarios followed by random
// traffic, every cycle compared against a behavioural reference model.
module tb_reset_ctrl;
  import reset_pkg::*;

  localparam int H = 4;
  localparam int D = 8;
  localparam int W = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_n;
  logic       sw_rst_req;
  logic       wdt_en;
  logic       wdt_kick;
  logic       sys_rst_n;
  logic [3:0] rst_cause;
  logic [4:0] wdt_count;

  int n_cmp = 0;
  int n_err = 0;
  int lows;
  int n;

  // Reference model: run flag, edges left in the hold window, cause,
  // watchdog count, and a history of raw button samples (newest first).
  bit       m_run;
  int       m_hold_left;
  logic [3:0] m_cause;
  int       m_wdt;
  bit       bq[$];

  reset_ctrl #(
    .HOLD_CYCLES    (H),
    .DEBOUNCE_CYCLES(D),
    .WDT_CYCLES     (W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_n      (btn_n),
    .sw_rst_req (sw_rst_req),
    .wdt_en     (wdt_en),
    .wdt_kick   (wdt_kick),
    .sys_rst_n  (sys_rst_n),
    .rst_cause  (rst_cause),
    .wdt_count  (wdt_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, want, $time);
    end
  endtask

  function automatic void model_reset();
    m_run       = 1'b0;
    m_hold_left = H;
    m_cause     = 4'b0001;
    m_wdt       = 0;
    bq.delete();
    for (int i = 0; i < D + 2; i++) bq.push_back(1'b1);
  endfunction

  // Pressed in this cycle when the synchronized button (two samples late)
  // has read low for the previous D-1 cycles.
  function automatic bit m_pressed();
    for (int i = 2; i <= D; i++) if (bq[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void model_edge();
    bit p, fire, req, was_run;
    if (rst) begin
      model_reset();
      return;
    end
    p       = m_pressed();
    was_run = m_run;
    fire    = m_run && wdt_en && !wdt_kick && (m_wdt == W - 1);
    req     = fire || sw_rst_req || p;
    if (m_run) begin
      if (req) begin
        m_run       = 1'b0;
        m_hold_left = H;
        m_cause     = {fire, sw_rst_req, p, 1'b0};
      end
    end else if (p) begin
      m_hold_left = H;
    end else begin
      m_hold_left--;
      if (m_hold_left == 0) m_run = 1'b1;
    end
    m_wdt = (was_run && wdt_en && !wdt_kick && !req) ? m_wdt + 1 : 0;
    bq.push_front(btn_n);
    void'(bq.pop_back());
  endfunction

  task automatic compare_outputs(input string tag);
    check({tag, ".rst_n"}, 32'(sys_rst_n), 32'(m_run));
    check({tag, ".cause"}, 32'(rst_cause), 32'(m_cause));
    if (m_run) check({tag, ".wdt"}, 32'(wdt_count), 32'(m_wdt));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    compare_outputs(tag);
  endtask

  // Count observed low cycles of sys_rst_n, starting with the current one.
  task automatic measure_low(input string tag, input int want);
    int k = 0;
    while (sys_rst_n === 1'b0 && k < 200) begin
      k++;
      step(tag);
    end
    check({tag, ".len"}, 32'(k), 32'(want));
  endtask

  // Count edges until sys_rst_n is observed low.
  task automatic wait_fall(input string tag, input int want);
    int k = 0;
    while (sys_rst_n === 1'b1 && k < 200) begin
      k++;
      step(tag);
    end
    check({tag, ".lat"}, 32'(k), 32'(want));
  endtask

  task automatic wait_wdt_term(input string tag);
    int k = 0;
    while (m_wdt != W - 1 && k < 64) begin
      k++;
      step(tag);
    end
    check({tag, ".at_term"}, 32'(wdt_count), 32'(W - 1));
  endtask

  initial begin
    rst = 1'b1; btn_n = 1'b1; sw_rst_req = 1'b0; wdt_en = 1'b0; wdt_kick = 1'b0;
    model_reset();
    #2;
    compare_outputs("reset");
    check("reset.wdt", 32'(wdt_count), 32'(0));

    // 1. Power-on reset: rst held 3 edges, then exactly H low cycles.
    repeat (3) step("por_rst");
    rst = 1'b0;
    measure_low("por", H);
    check("por.cause", 32'(rst_cause), 32'(CAUSE_POR));

    // 2. Software request.
    repeat (5) step("idle");
    sw_rst_req = 1'b1;
    step("sw");
    sw_rst_req = 1'b0;
    measure_low("sw", H);
    check("sw.cause", 32'(rst_cause), 32'(CAUSE_SW));

    // 3. Button bounce rejected, then a real 20-cycle press.
    repeat (3) step("idle");
    btn_n = 1'b0;
    repeat (5) step("bounce");
    btn_n = 1'b1;
    repeat (15) step("bounce");
    check("bounce.rst_n", 32'(sys_rst_n), 32'(1));
    btn_n = 1'b0;
    wait_fall("btn", D + 2);
    repeat (20 - (D + 2)) step("btn_hold");
    btn_n = 1'b1;
    measure_low("btn_rel", H + 3);
    check("btn.cause", 32'(rst_cause), 32'(CAUSE_BTN));

    // 4. Watchdog fire with no kicks, regular kicks, terminal-cycle kick.
    repeat (3) step("idle");
    wdt_en = 1'b1;
    wait_fall("wdt", W);
    check("wdt.cause", 32'(rst_cause), 32'(CAUSE_WDT));
    measure_low("wdt_hold", H);
    lows = 0;
    for (int i = 0; i < 500; i++) begin
      wdt_kick = (i % 20 == 19);
      step("kick");
      if (sys_rst_n !== 1'b1) lows++;
    end
    wdt_kick = 1'b0;
    check("kick.no_rst", 32'(lows), 32'(0));
    wait_wdt_term("term");
    wdt_kick = 1'b1;
    step("term_kick");
    wdt_kick = 1'b0;
    check("term_kick.rst_n", 32'(sys_rst_n), 32'(1));
    check("term_kick.wdt", 32'(wdt_count), 32'(0));

    // 5. Simultaneous software + watchdog; software ignored during hold.
    wait_wdt_term("simul");
    sw_rst_req = 1'b1;
    step("simul");
    check("simul.cause", 32'(rst_cause), 32'(CAUSE_SW | CAUSE_WDT));
    repeat (H - 1) step("hold_sw");
    check("hold_sw.low", 32'(sys_rst_n), 32'(0));
    step("hold_sw");
    sw_rst_req = 1'b0;
    check("hold_sw.high", 32'(sys_rst_n), 32'(1));
    check("hold_sw.cause", 32'(rst_cause), 32'(CAUSE_SW | CAUSE_WDT));

    // 6. rst asserted mid-hold after a watchdog reset.
    wait_fall("wdt2", W);
    check("wdt2.cause", 32'(rst_cause), 32'(CAUSE_WDT));
    step("mid_hold");
    rst = 1'b1;
    #1;
    model_reset();
    compare_outputs("async_rst");
    check("async_rst.cause", 32'(rst_cause), 32'(CAUSE_POR));
    check("async_rst.wdt", 32'(wdt_count), 32'(0));
    repeat (2) step("async_rst");
    rst = 1'b0;
    wdt_en = 1'b0;
    measure_low("post_rst", H);
    check("post_rst.cause", 32'(rst_cause), 32'(CAUSE_POR));

    // 7. Random traffic against the model.
    wdt_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(11) == 0) btn_n = ~btn_n;
      sw_rst_req = ($urandom_range(39) == 0);
      wdt_kick   = ($urandom_range(39) == 0);
      if ($urandom_range(59) == 0) wdt_en = ~wdt_en;
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(399) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        compare_outputs("rnd_async");
      end
      step("rnd");
    end

    n = n_err;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n);
    $finish;
  end

endmodule
